// File: rtl/key_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_cmd_pkg
//  Description : Shared types and helpers for the key-driven EEPROM command
//                sequencer: command record, read/write encoding, FSM state
//                type and the debounce-length calculation.
//  Revision    : 1.0  initial release
// ============================================================================
package key_cmd_pkg;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } state_t;

    // Number of identical synchronised samples a key level needs before it is
    // believed.
    function automatic int unsigned db_cycles(input int unsigned clk_hz,
                                              input int unsigned debounce_ms);
        return (clk_hz / 1000) * debounce_ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchroniser plus debounce counter for one active-low
//                push key. Emits a single-cycle pulse when a press (1->0) is
//                accepted; releases produce nothing.
//  Ports       : clk, rst     clock / synchronous active-high reset
//                i_key_n      raw asynchronous key, 0 = pressed
//                o_press      1-cycle pulse on accepted press
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned     c_CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DB_CYCLES - 1);

    logic            r_meta;
    logic            r_sync;
    logic            r_stable;
    logic            r_press;
    logic [c_CW-1:0] r_cnt;

    // r_cnt counts consecutive samples that disagree with the accepted level;
    // any sample that agrees again throws the run away.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_meta  <= i_key_n;
            r_sync  <= r_meta;
            r_press <= 1'b0;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
                r_press  <= ~r_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/key_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : key_cmd_sequencer
//  Description : Turns debounced write/read key presses into queued EEPROM
//                commands with auto-incrementing address/data, issues them one
//                at a time over valid/ready and waits for each response.
//                Captures read data, flags NACK/timeout errors.
//  Ports       : key_wr_n/key_rd_n   raw keys (0 = pressed)
//                cmd_*               command handshake to the I2C byte engine
//                rsp_*               engine response (rsp_valid 1-cycle pulse)
//                last_rdata, busy, err, drop_cnt, verify_fail  status
//  Option      : KEY_CMD_VERIFY_EN  - compare readback against the last
//                acknowledged write to the same address (verify_fail).
//  Revision    : 1.0  initial release
// ============================================================================
module key_cmd_sequencer
    import key_cmd_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [7:0]  BASE_ADDR   = 8'h1E,
    parameter logic [7:0]  DATA_INIT   = 8'h05,
    parameter int unsigned RSP_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_wr_n,
    input  logic       key_rd_n,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_rw,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_wdata,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    input  logic [7:0] rsp_rdata,
    output logic [7:0] last_rdata,
    output logic       busy,
    output logic       err,
    output logic [7:0] drop_cnt,
    output logic       verify_fail
);

    localparam int unsigned     c_DB         = db_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned     c_AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned     c_TW         = $clog2(RSP_TIMEOUT);
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(RSP_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Key front ends
    // ------------------------------------------------------------------
    logic w_wr_press;
    logic w_rd_press;

    key_debounce #(.DB_CYCLES(c_DB)) u_db_wr (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_wr_n),
        .o_press (w_wr_press)
    );

    key_debounce #(.DB_CYCLES(c_DB)) u_db_rd (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (key_rd_n),
        .o_press (w_rd_press)
    );

    // ------------------------------------------------------------------
    // Push arbitration: one push per cycle, write wins, a colliding read
    // is held in r_rd_pend and pushed on the following cycle.
    // ------------------------------------------------------------------
    logic       r_rd_pend;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_rd_addr;
    logic [7:0] r_drop_cnt;

    logic w_push_wr;
    logic w_push_rd;
    logic w_push;
    logic w_accept;
    logic w_drop;
    logic w_pop;
    logic w_empty;
    logic w_full;
    cmd_t w_push_cmd;
    cmd_t w_head;

    assign w_push_wr = w_wr_press;
    assign w_push_rd = !w_wr_press && (w_rd_press || r_rd_pend);
    assign w_push    = w_push_wr || w_push_rd;
    assign w_accept  = w_push && !w_full;
    assign w_drop    = w_push && w_full;

    always_comb begin
        w_push_cmd.rw   = RW_WRITE;
        w_push_cmd.addr = r_wr_addr;
        w_push_cmd.data = r_wr_data;
        if (w_push_rd) begin
            w_push_cmd.rw   = RW_READ;
            w_push_cmd.addr = r_rd_addr;
            w_push_cmd.data = 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through command queue. Pointers carry one extra
    // wrap bit so full and empty are distinguishable.
    // ------------------------------------------------------------------
    cmd_t          r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wptr;
    logic [c_AW:0] r_rptr;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_head  = r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr[c_AW-1:0]] <= w_push_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_pend  <= 1'b0;
            r_wr_addr  <= BASE_ADDR;
            r_wr_data  <= DATA_INIT;
            r_rd_addr  <= BASE_ADDR;
            r_drop_cnt <= 8'h00;
        end else begin
            r_rd_pend <= w_wr_press && (w_rd_press || r_rd_pend);
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
                if (w_push_wr) begin
                    r_wr_addr <= r_wr_addr + 8'h01;
                    r_wr_data <= r_wr_data + 8'h01;
                end else begin
                    r_rd_addr <= r_rd_addr + 8'h01;
                end
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'h01;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command / response FSM
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [c_TW-1:0] r_timer;
    logic            r_cur_rw;
    logic            r_err;
    logic [7:0]      r_last_rdata;

    assign w_pop = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_cur_rw     <= RW_WRITE;
            r_err        <= 1'b0;
            r_last_rdata <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state  <= WAIT_RSP;
                        r_timer  <= '0;
                        r_cur_rw <= w_head.rw;
                    end
                end
                WAIT_RSP: begin
                    r_timer <= r_timer + 1'b1;
                    if (rsp_valid) begin
                        r_state <= IDLE;
                        if (rsp_nack) begin
                            r_err <= 1'b1;
                        end else if (r_cur_rw == RW_READ) begin
                            r_last_rdata <= rsp_rdata;
                        end
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional readback verification
    // ------------------------------------------------------------------
`ifdef KEY_CMD_VERIFY_EN
    logic       r_cur_wrt;
    logic [7:0] r_cur_addr;
    logic [7:0] r_cur_data;
    logic       r_shadow_vld;
    logic [7:0] r_shadow_addr;
    logic [7:0] r_shadow_data;
    logic       r_verify_fail;
    logic       w_rsp_ok;

    assign w_rsp_ok = (r_state == WAIT_RSP) && rsp_valid && !rsp_nack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_wrt     <= 1'b0;
            r_cur_addr    <= 8'h00;
            r_cur_data    <= 8'h00;
            r_shadow_vld  <= 1'b0;
            r_shadow_addr <= 8'h00;
            r_shadow_data <= 8'h00;
            r_verify_fail <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cur_wrt  <= (w_head.rw == RW_WRITE);
                r_cur_addr <= w_head.addr;
                r_cur_data <= w_head.data;
            end
            if (w_rsp_ok) begin
                if (r_cur_wrt) begin
                    r_shadow_vld  <= 1'b1;
                    r_shadow_addr <= r_cur_addr;
                    r_shadow_data <= r_cur_data;
                end else if (r_shadow_vld && (r_cur_addr == r_shadow_addr) &&
                             (rsp_rdata != r_shadow_data)) begin
                    r_verify_fail <= 1'b1;
                end
            end
        end
    end

    assign verify_fail = r_verify_fail;
`else
    assign verify_fail = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs. Command fields read as zero while the queue is empty so the
    // bus is quiet out of reset.
    // ------------------------------------------------------------------
    assign cmd_valid  = (r_state == IDLE) && !w_empty;
    assign cmd_rw     = !w_empty && w_head.rw;
    assign cmd_addr   = w_empty ? 8'h00 : w_head.addr;
    assign cmd_wdata  = w_empty ? 8'h00 : w_head.data;
    assign last_rdata = r_last_rdata;
    assign busy       = !w_empty || (r_state == WAIT_RSP);
    assign err        = r_err;
    assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_key_cmd_sequencer
//  Description : Self-checking bench for key_cmd_sequencer. Directed scenarios
//                followed by randomized press / response rounds, all checked
//                against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_cmd_sequencer;

    localparam int unsigned CLK_HZ      = 10_000;
    localparam int unsigned DEBOUNCE_MS = 20;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned RSP_TIMEOUT = 4096;
    localparam int          HOLD        = 240;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_wr_n = 1'b1;
    logic       key_rd_n = 1'b1;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic       cmd_rw;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid = 1'b0;
    logic       rsp_nack = 1'b0;
    logic [7:0] rsp_rdata = 8'h00;
    logic [7:0] last_rdata;
    logic       busy;
    logic       err;
    logic [7:0] drop_cnt;
    logic       verify_fail;

    key_cmd_sequencer #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .BASE_ADDR   (8'h1E),
        .DATA_INIT   (8'h05),
        .RSP_TIMEOUT (RSP_TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .key_wr_n    (key_wr_n),
        .key_rd_n    (key_rd_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_nack    (rsp_nack),
        .rsp_rdata   (rsp_rdata),
        .last_rdata  (last_rdata),
        .busy        (busy),
        .err         (err),
        .drop_cnt    (drop_cnt),
        .verify_fail (verify_fail)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
    } m_cmd_t;

    m_cmd_t     m_q[$];
    m_cmd_t     m_cur;
    logic [7:0] m_wr_addr, m_wr_data, m_rd_addr, m_drop, m_last;
    logic       m_err, m_vfail, m_sh_vld;
    logic [7:0] m_sh_addr, m_sh_data;

    task automatic model_reset();
        m_q.delete();
        m_wr_addr = 8'h1E;
        m_wr_data = 8'h05;
        m_rd_addr = 8'h1E;
        m_drop    = 8'h00;
        m_last    = 8'h00;
        m_err     = 1'b0;
        m_vfail   = 1'b0;
        m_sh_vld  = 1'b0;
        m_sh_addr = 8'h00;
        m_sh_data = 8'h00;
    endtask

    task automatic m_push(input logic rw);
        m_cmd_t c;
        if (m_q.size() >= FIFO_DEPTH) begin
            if (m_drop != 8'hFF) m_drop = m_drop + 8'h01;
        end else if (rw == 1'b0) begin
            c = '{rw: 1'b0, addr: m_wr_addr, data: m_wr_data};
            m_q.push_back(c);
            m_wr_addr = m_wr_addr + 8'h01;
            m_wr_data = m_wr_data + 8'h01;
        end else begin
            c = '{rw: 1'b1, addr: m_rd_addr, data: 8'h00};
            m_q.push_back(c);
            m_rd_addr = m_rd_addr + 8'h01;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (all return on a falling edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic press(input logic wr, input logic rd);
        key_wr_n = !wr;
        key_rd_n = !rd;
        repeat (HOLD) tick();
        key_wr_n = 1'b1;
        key_rd_n = 1'b1;
        repeat (HOLD) tick();
        if (wr) m_push(1'b0);
        if (rd) m_push(1'b1);
    endtask

    // Waits for the head command, checks it, lets it be accepted.
    task automatic accept();
        m_cmd_t e;
        cmd_ready = 1'b1;
        for (int i = 0; i < 50 && !cmd_valid; i++) tick();
        chk("cmd_valid_wait", {31'd0, cmd_valid}, 32'd1);
        e = m_q.pop_front();
        m_cur = e;
        if (cmd_valid) begin
            chk("cmd_rw", {31'd0, cmd_rw}, {31'd0, e.rw});
            chk("cmd_addr", {24'd0, cmd_addr}, {24'd0, e.addr});
            if (!e.rw) chk("cmd_wdata", {24'd0, cmd_wdata}, {24'd0, e.data});
        end
        tick();
        cmd_ready = 1'b0;
        chk("cmd_valid_in_wait", {31'd0, cmd_valid}, 32'd0);
    endtask

    task automatic respond(input logic nack, input logic [7:0] rdata, input int delay);
        repeat (delay) tick();
        rsp_valid = 1'b1;
        rsp_nack  = nack;
        rsp_rdata = rdata;
        tick();
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        if (nack) begin
            m_err = 1'b1;
        end else if (m_cur.rw) begin
            m_last = rdata;
`ifdef KEY_CMD_VERIFY_EN
            if (m_sh_vld && (m_sh_addr == m_cur.addr) && (rdata != m_sh_data)) m_vfail = 1'b1;
`endif
        end else begin
`ifdef KEY_CMD_VERIFY_EN
            m_sh_vld  = 1'b1;
            m_sh_addr = m_cur.addr;
            m_sh_data = m_cur.data;
`endif
        end
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("last_rdata", {24'd0, last_rdata}, {24'd0, m_last});
        chk("verify_fail", {31'd0, verify_fail}, {31'd0, m_vfail});
        chk("busy_after_rsp", {31'd0, busy}, {31'd0, (m_q.size() > 0)});
    endtask

    task automatic drain_ok();
        while (m_q.size() > 0) begin
            accept();
            respond(1'b0, 8'h00, 2);
        end
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #(10 * 95_000);
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        model_reset();
        tick();
        do_reset();

        // Reset state
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_cmd_rw", {31'd0, cmd_rw}, 32'd0);
        chk("rst_cmd_addr", {24'd0, cmd_addr}, 32'd0);
        chk("rst_cmd_wdata", {24'd0, cmd_wdata}, 32'd0);
        chk("rst_last_rdata", {24'd0, last_rdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        chk("rst_verify", {31'd0, verify_fail}, 32'd0);

        // Two write presses: 1E/05 then 1F/06
        press(1'b1, 1'b0);
        accept();
        respond(1'b0, 8'h00, 3);
        press(1'b1, 1'b0);
        accept();
        respond(1'b0, 8'h00, 3);

        // Bouncing read key: nothing until it settles low
        do_reset();
        for (int i = 0; i < 20; i++) begin
            key_rd_n = ~key_rd_n;
            repeat (50) tick();
        end
        key_rd_n = 1'b1;
        chk("bounce_busy", {31'd0, busy}, 32'd0);
        press(1'b0, 1'b1);
        chk("bounce_one_cmd", {31'd0, busy}, 32'd1);
        accept();
        respond(1'b0, 8'h3C, 1);
        chk("bounce_queue_empty", {31'd0, busy}, 32'd0);

        // Queue overflow with ready held low
        do_reset();
        repeat (6) press(1'b1, 1'b0);
        chk("ovf_drop", {24'd0, drop_cnt}, {24'd0, m_drop});
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        drain_ok();

        // Simultaneous presses, including a read lost to a full queue
        do_reset();
        press(1'b1, 1'b1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        chk("both_drop", {24'd0, drop_cnt}, {24'd0, m_drop});
        drain_ok();
        press(1'b0, 1'b1);
        drain_ok();

        // Read data capture, NACK error, response while idle ignored
        do_reset();
        press(1'b0, 1'b1);
        accept();
        respond(1'b0, 8'hA5, 4);
        rsp_valid = 1'b1;
        rsp_nack  = 1'b1;
        rsp_rdata = 8'h11;
        tick();
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        tick();
        chk("idle_rsp_err", {31'd0, err}, 32'd0);
        chk("idle_rsp_rdata", {24'd0, last_rdata}, 32'h0A5);
        press(1'b0, 1'b1);
        accept();
        respond(1'b1, 8'h77, 2);

        // Response timeout, exact boundary
        do_reset();
        press(1'b1, 1'b0);
        accept();
        repeat (RSP_TIMEOUT - 1) tick();
        chk("to_busy_before", {31'd0, busy}, 32'd1);
        chk("to_err_before", {31'd0, err}, 32'd0);
        tick();
        chk("to_err_after", {31'd0, err}, 32'd1);
        chk("to_busy_after", {31'd0, busy}, 32'd0);

        // Reset during WAIT_RSP, late response ignored
        press(1'b1, 1'b0);
        accept();
        repeat (5) tick();
        do_reset();
        chk("midrst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        rsp_valid = 1'b1;
        rsp_nack  = 1'b1;
        tick();
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        tick();
        chk("midrst_late_rsp", {31'd0, err}, 32'd0);
        press(1'b1, 1'b0);
        accept();
        respond(1'b0, 8'h00, 1);

        // Readback verification: write 05@1E, read back 07
        do_reset();
        press(1'b1, 1'b0);
        accept();
        respond(1'b0, 8'h00, 2);
        press(1'b0, 1'b1);
        accept();
        respond(1'b0, 8'h07, 2);
`ifdef KEY_CMD_VERIFY_EN
        chk("verify_set", {31'd0, verify_fail}, 32'd1);
`else
        chk("verify_tied", {31'd0, verify_fail}, 32'd0);
`endif

        // Randomized rounds
        do_reset();
        for (int r = 0; r < 10; r++) begin
            int k;
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
                case ($urandom_range(0, 2))
                    0:       press(1'b1, 1'b0);
                    1:       press(1'b0, 1'b1);
                    default: press(1'b1, 1'b1);
                endcase
            end
            chk("rnd_drop", {24'd0, drop_cnt}, {24'd0, m_drop});
            chk("rnd_busy", {31'd0, busy}, {31'd0, (m_q.size() > 0)});
            while (m_q.size() > 0) begin
                logic       nk;
                logic [7:0] rd;
                nk = ($urandom_range(0, 4) == 0);
                rd = 8'($urandom);
                accept();
                respond(nk, rd, $urandom_range(0, 8));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
